// File: rtl/syn_fifo_ctrl.sv
// Single-clock FIFO controller with occupancy count, almost-full/empty thresholds,
// write/read acknowledges and full-with-read pass-through. Define SYN_FIFO_ERR_FLAGS_EN
// to add sticky overflow/underflow flags with an err_clr input.
module syn_fifo_ctrl #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rdata,
    output logic              rd_valid,
    output logic              wr_ack,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count
`ifdef SYN_FIFO_ERR_FLAGS_EN
    ,
    input  logic              err_clr,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_CNT    = (ADDR_W + 1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_CNT    = (ADDR_W + 1)'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W:0]   wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W:0]   rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic [DATA_W-1:0] rdata_reg;
    logic              rd_valid_reg;
    logic              wr_ack_reg;

    logic              rd_acc;
    logic              wr_acc;

    // Status is derived from the count register alone, so no request input
    // has a combinational path to any flag.
    assign empty        = (count_reg == '0);
    assign full         = (count_reg == DEPTH_CNT);
    assign almost_full  = (count_reg >= AF_CNT);
    assign almost_empty = (count_reg <= AE_CNT);
    assign count        = count_reg;

    assign rdata    = rdata_reg;
    assign rd_valid = rd_valid_reg;
    assign wr_ack   = wr_ack_reg;

    // A full FIFO still takes a write when a read frees a slot in the same cycle;
    // an empty FIFO never reads, so a write there is not visible until next cycle.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (wr_acc) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (rd_acc) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + PTR_ONE;
            2'b01:   count_next = count_reg - PTR_ONE;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            wr_ack_reg   <= 1'b0;
            rd_valid_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            wr_ack_reg   <= wr_acc;
            rd_valid_reg <= rd_acc;
        end
    end

    // Storage has no reset so it maps onto block RAM; the write is still
    // suppressed during reset so a request in that cycle leaves no trace.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_reg <= '0;
        end else if (rd_acc) begin
            rdata_reg <= mem[rd_ptr_reg[ADDR_W-1:0]];
        end
    end

`ifdef SYN_FIFO_ERR_FLAGS_EN
    logic overflow_reg, overflow_next;
    logic underflow_reg, underflow_next;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_comb begin
        overflow_next  = err_clr ? 1'b0 : overflow_reg;
        underflow_next = err_clr ? 1'b0 : underflow_reg;
        if (wr_en && !wr_acc) begin
            overflow_next = 1'b1;
        end
        if (rd_en && empty) begin
            underflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_syn_fifo_ctrl.sv
// Randomised and directed bench for syn_fifo_ctrl (DEPTH=16, DATA_W=8) against a
// queue-based reference model; covers SYN_FIFO_ERR_FLAGS_EN when that macro is defined.
module tb_syn_fifo_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          rd_valid;
    logic          wr_ack;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
`ifdef SYN_FIFO_ERR_FLAGS_EN
    logic          err_clr;
    logic          overflow;
    logic          underflow;
`endif

    always #5 clk = ~clk;

    syn_fifo_ctrl #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wdata        (wdata),
        .rd_en        (rd_en),
        .rdata        (rdata),
        .rd_valid     (rd_valid),
        .wr_ack       (wr_ack),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
`ifdef SYN_FIFO_ERR_FLAGS_EN
        ,
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: contents as a queue plus the expected registered outputs.
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_rdata;
    bit            exp_rd_valid;
    bit            exp_wr_ack;
    bit            exp_ovf;
    bit            exp_unf;

    task automatic drive(input bit rst_v, input bit wr, input bit rd,
                         input logic [DW-1:0] d, input bit clr);
        bit ra;
        bit wa;
        bit was_empty;
        bit was_full;
        rst_n = rst_v;
        wr_en = wr;
        rd_en = rd;
        wdata = d;
`ifdef SYN_FIFO_ERR_FLAGS_EN
        err_clr = clr;
`endif
        if (!rst_v) begin
            q.delete();
            exp_rdata    = '0;
            exp_rd_valid = 1'b0;
            exp_wr_ack   = 1'b0;
            exp_ovf      = 1'b0;
            exp_unf      = 1'b0;
        end else begin
            was_empty = (q.size() == 0);
            was_full  = (q.size() == DEPTH);
            ra = rd && !was_empty;
            wa = wr && (!was_full || ra);
            if (clr) begin
                exp_ovf = 1'b0;
                exp_unf = 1'b0;
            end
            if (wr && !wa) exp_ovf = 1'b1;
            if (rd && was_empty) exp_unf = 1'b1;
            exp_rd_valid = ra;
            exp_wr_ack   = wa;
            if (ra) exp_rdata = q.pop_front();
            if (wa) q.push_back(d);
        end
        @(posedge clk);
        #1;
        $display("txn t=%0t rst_n=%b wr=%b rd=%b wdata=%h -> rdata=%h rd_valid=%b wr_ack=%b count=%0d",
                 $time, rst_v, wr, rd, d, rdata, rd_valid, wr_ack, count);
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
`ifdef SYN_FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_almost_empty: got %b want 1", almost_empty); end
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full: got %b want 0", almost_full); end
        n_cmp++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL reset_wr_ack: got %b want 0", wr_ack); end
`ifdef SYN_FIFO_ERR_FLAGS_EN
        n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_fail++; $display("FAIL reset_err_flags: got %b%b want 00", overflow, underflow); end
`endif
    endtask

    task automatic test_fill_full();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(i), 1'b0);
            n_cmp++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL fill_wr_ack[%0d]: got %b want 1", i, wr_ack); end
            n_cmp++; if (count !== 5'(i)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i); end
            n_cmp++; if (almost_full !== (i >= AF)) begin n_fail++; $display("FAIL fill_almost_full[%0d]: got %b want %b", i, almost_full, (i >= AF)); end
            n_cmp++; if (full !== (i == DEPTH)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == DEPTH)); end
            n_cmp++; if (almost_empty !== (i <= AE)) begin n_fail++; $display("FAIL fill_almost_empty[%0d]: got %b want %b", i, almost_empty, (i <= AE)); end
        end
        drive(1'b1, 1'b1, 1'b0, 8'hFF, 1'b0);
        n_cmp++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL overfill_wr_ack: got %b want 0", wr_ack); end
        n_cmp++; if (count !== 5'd16) begin n_fail++; $display("FAIL overfill_count: got %0d want 16", count); end
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL overfill_full: got %b want 1", full); end
`ifdef SYN_FIFO_ERR_FLAGS_EN
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overfill_overflow: got %b want 1", overflow); end
`endif
    endtask

    task automatic test_full_passthrough();
        logic [DW-1:0] want;
        drive(1'b1, 1'b1, 1'b1, 8'hAA, 1'b1);
        n_cmp++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL fullrw_rd_valid: got %b want 1", rd_valid); end
        n_cmp++; if (rdata !== 8'h01) begin n_fail++; $display("FAIL fullrw_rdata: got %h want 01", rdata); end
        n_cmp++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL fullrw_wr_ack: got %b want 1", wr_ack); end
        n_cmp++; if (count !== 5'd16) begin n_fail++; $display("FAIL fullrw_count: got %0d want 16", count); end
`ifdef SYN_FIFO_ERR_FLAGS_EN
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fullrw_overflow_clr: got %b want 0", overflow); end
`endif
        for (int i = 0; i < DEPTH; i++) begin
            want = (i < DEPTH - 1) ? 8'(i + 2) : 8'hAA;
            drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
            n_cmp++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL drain_rd_valid[%0d]: got %b want 1", i, rd_valid); end
            n_cmp++; if (rdata !== want) begin n_fail++; $display("FAIL drain_rdata[%0d]: got %h want %h", i, rdata, want); end
        end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", empty); end
    endtask

    task automatic test_empty_rw();
        drive(1'b1, 1'b1, 1'b1, 8'h55, 1'b0);
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL emptyrw_rd_valid: got %b want 0", rd_valid); end
        n_cmp++; if (count !== 5'd1) begin n_fail++; $display("FAIL emptyrw_count: got %0d want 1", count); end
        n_cmp++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL emptyrw_wr_ack: got %b want 1", wr_ack); end
`ifdef SYN_FIFO_ERR_FLAGS_EN
        n_cmp++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL emptyrw_underflow: got %b want 1", underflow); end
`endif
        drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
        n_cmp++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL emptyrw_next_rd_valid: got %b want 1", rd_valid); end
        n_cmp++; if (rdata !== 8'h55) begin n_fail++; $display("FAIL emptyrw_next_rdata: got %h want 55", rdata); end
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL emptyrw_next_count: got %0d want 0", count); end
`ifdef SYN_FIFO_ERR_FLAGS_EN
        n_cmp++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL emptyrw_underflow_clr: got %b want 0", underflow); end
`endif
    endtask

    task automatic test_stream_random();
        int  writes = 0;
        int  reads  = 0;
        int  cycles = 0;
        bit  wr;
        bit  rd;
        bit  clr;
        int  sz;
        while ((writes < 40 || reads < 40) && cycles < 2000) begin
            wr  = (writes < 40) && ($urandom_range(0, 2) != 0);
            rd  = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 7) == 0);
            drive(1'b1, wr, rd, 8'($urandom), clr);
            cycles++;
            if (exp_wr_ack) writes++;
            if (exp_rd_valid) reads++;
            sz = q.size();
            n_cmp++; if (count !== 5'(sz)) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d want %0d", cycles, count, sz); end
            n_cmp++; if (int'(count) !== writes - reads || count > 5'd16) begin n_fail++; $display("FAIL stream_balance[%0d]: got %0d want %0d", cycles, count, writes - reads); end
            n_cmp++; if (rd_valid !== exp_rd_valid) begin n_fail++; $display("FAIL stream_rd_valid[%0d]: got %b want %b", cycles, rd_valid, exp_rd_valid); end
            n_cmp++; if (rdata !== exp_rdata) begin n_fail++; $display("FAIL stream_rdata[%0d]: got %h want %h", cycles, rdata, exp_rdata); end
            n_cmp++; if (wr_ack !== exp_wr_ack) begin n_fail++; $display("FAIL stream_wr_ack[%0d]: got %b want %b", cycles, wr_ack, exp_wr_ack); end
            n_cmp++; if ({full, empty, almost_full, almost_empty} !== {sz == DEPTH, sz == 0, sz >= AF, sz <= AE})
                begin n_fail++; $display("FAIL stream_status[%0d]: got %b%b%b%b want %b%b%b%b", cycles, full, empty, almost_full, almost_empty, sz == DEPTH, sz == 0, sz >= AF, sz <= AE); end
`ifdef SYN_FIFO_ERR_FLAGS_EN
            n_cmp++; if ({overflow, underflow} !== {exp_ovf, exp_unf}) begin n_fail++; $display("FAIL stream_err_flags[%0d]: got %b%b want %b%b", cycles, overflow, underflow, exp_ovf, exp_unf); end
`endif
        end
        n_cmp++; if (writes != 40 || reads != 40) begin n_fail++; $display("FAIL stream_timeout: got %0d writes %0d reads want 40/40", writes, reads); end
    endtask

    task automatic test_reset_midway();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, 1'b0, 8'(8'h30 + i), 1'b0);
        end
        n_cmp++; if (count !== 5'd10) begin n_fail++; $display("FAIL midrst_prefill_count: got %0d want 10", count); end
        drive(1'b0, 1'b1, 1'b0, 8'h77, 1'b0);
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", count); end
        n_cmp++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin n_fail++; $display("FAIL midrst_status: got %b%b%b%b want 1100", empty, almost_empty, full, almost_full); end
        n_cmp++; if ({rd_valid, wr_ack} !== 2'b00) begin n_fail++; $display("FAIL midrst_handshake: got %b%b want 00", rd_valid, wr_ack); end
        n_cmp++; if (rdata !== 8'h00) begin n_fail++; $display("FAIL midrst_rdata: got %h want 00", rdata); end
        drive(1'b1, 1'b0, 1'b1, 8'h00, 1'b0);
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_write_rd_valid: got %b want 0", rd_valid); end
        n_cmp++; if (count !== 5'd0) begin n_fail++; $display("FAIL midrst_no_write_count: got %0d want 0", count); end
    endtask

    initial begin
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = '0;
`ifdef SYN_FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
        test_reset();
        test_fill_full();
        test_full_passthrough();
        test_empty_rw();
        test_stream_random();
        test_reset_midway();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
